// File: rtl/lfsr_rng_arbiter.sv
// Seeds and warms an external 8-bit LFSR, then shares its values round-robin among requesters
// with per-request range reduction. Define RNG_STATS_EN to build the grant/reject counters.
module lfsr_rng_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WARMUP    = 4,
    parameter logic [7:0]  SAFE_SEED = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           seed_i,
    input  logic                 seed_start_i,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [2*NUM_REQ-1:0] mode_i,
    output logic [7:0]           lfsr_seed_o,
    output logic                 lfsr_in_valid_o,
    input  logic [7:0]           lfsr_rnd_i,
    output logic [NUM_REQ-1:0]   gnt_o,
    output logic [7:0]           rnd_o,
    output logic                 rnd_valid_o,
    output logic                 ready_o,
    output logic [15:0]          stat_grant_cnt_o,
    output logic [15:0]          stat_reject_cnt_o
);

    localparam int unsigned PtrW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CandW = PtrW + 1;
    localparam logic [PtrW-1:0] LastIdx  = PtrW'(NUM_REQ - 1);
    localparam logic [7:0]      WarmLast = (WARMUP > 0) ? 8'(WARMUP - 1) : 8'd0;

    typedef enum logic [1:0] {StIdle, StSeed, StWarm, StRun} state_e;

    state_e state_q, state_d;

    logic [7:0]         seed_q;
    logic [7:0]         warm_cnt_q;
    logic [PtrW-1:0]    ptr_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] gnt_d;
    logic [7:0]         rnd_q;

    logic               sel_found;
    logic [PtrW-1:0]    sel_idx;
    logic [CandW-1:0]   cand;
    logic [1:0]         sel_mode;
    logic               accept;
    logic [7:0]         red_val;
    logic               arb_active;
    logic               grant_now;
    logic [PtrW-1:0]    ptr_next;

    // (r-1) mod 40 + 1 for r in 1..240, by conditional subtraction of 160, 80, 40.
    function automatic logic [7:0] mod40_plus1(input logic [7:0] r);
        logic [7:0] m;
        m = r - 8'd1;
        if (m >= 8'd160) m = m - 8'd160;
        if (m >= 8'd80)  m = m - 8'd80;
        if (m >= 8'd40)  m = m - 8'd40;
        return m + 8'd1;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a seed request wins from any state
    always_comb begin
        state_d = state_q;
        if (seed_start_i) begin
            state_d = StSeed;
        end else begin
            unique case (state_q)
                StIdle: state_d = StIdle;
                StSeed: state_d = (WARMUP > 0) ? StWarm : StRun;
                StWarm: if (warm_cnt_q == WarmLast) state_d = StRun;
                StRun:  state_d = StRun;
                default: state_d = StIdle;
            endcase
        end
    end

    // State-decoded outputs
    always_comb begin
        lfsr_in_valid_o = (state_q == StSeed);
        ready_o         = (state_q == StRun);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seed_q     <= 8'd0;
            warm_cnt_q <= 8'd0;
        end else begin
            if (seed_start_i) begin
                seed_q <= (seed_i == 8'd0) ? SAFE_SEED : seed_i;
            end
            if (state_q == StWarm && state_d == StWarm) begin
                warm_cnt_q <= warm_cnt_q + 8'd1;
            end else begin
                warm_cnt_q <= 8'd0;
            end
        end
    end

    // First asserted request at or after the pointer, wrapping
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + CandW'(i);
            if (cand >= CandW'(NUM_REQ)) cand = cand - CandW'(NUM_REQ);
            if (!sel_found && req_i[cand[PtrW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[PtrW-1:0];
            end
        end
    end

    always_comb begin
        sel_mode = mode_i[{sel_idx, 1'b0} +: 2];
        accept   = 1'b1;
        red_val  = lfsr_rnd_i;
        unique case (sel_mode)
            2'd1: red_val = {6'b0, lfsr_rnd_i[1:0]};
            2'd2: begin
                accept  = (lfsr_rnd_i != 8'd0) && (lfsr_rnd_i <= 8'd240);
                red_val = mod40_plus1(lfsr_rnd_i);
            end
            default: red_val = lfsr_rnd_i;
        endcase
    end

    always_comb begin
        arb_active = (state_q == StRun) && !seed_start_i && sel_found;
        grant_now  = arb_active && accept;
        ptr_next   = (sel_idx == LastIdx) ? '0 : sel_idx + PtrW'(1);
        gnt_d      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            gnt_d[i] = grant_now && (sel_idx == PtrW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            gnt_q <= '0;
            rnd_q <= 8'd0;
        end else begin
            gnt_q <= gnt_d;
            if (grant_now) begin
                rnd_q <= red_val;
                ptr_q <= ptr_next;
            end
        end
    end

    assign lfsr_seed_o = seed_q;
    assign gnt_o       = gnt_q;
    assign rnd_o       = rnd_q;
    assign rnd_valid_o = |gnt_q;

`ifdef RNG_STATS_EN
    logic        reject_now;
    logic [15:0] grant_cnt_q;
    logic [15:0] reject_cnt_q;

    assign reject_now = arb_active && !accept;

    always_ff @(posedge clk) begin
        if (rst || seed_start_i) begin
            grant_cnt_q  <= 16'd0;
            reject_cnt_q <= 16'd0;
        end else begin
            if (grant_now && grant_cnt_q != 16'hFFFF) grant_cnt_q <= grant_cnt_q + 16'd1;
            if (reject_now && reject_cnt_q != 16'hFFFF) reject_cnt_q <= reject_cnt_q + 16'd1;
        end
    end

    assign stat_grant_cnt_o  = grant_cnt_q;
    assign stat_reject_cnt_o = reject_cnt_q;
`else
    assign stat_grant_cnt_o  = 16'd0;
    assign stat_reject_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Randomized bench for lfsr_rng_arbiter against a behavioural model, plus directed literal checks.
module tb_lfsr_rng_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [7:0]     seed_in = 8'd0;
    logic           seed_start = 1'b0;
    logic [N-1:0]   req = '0;
    logic [2*N-1:0] mode = '0;
    logic [7:0]     lfsr_seed_o;
    logic           lfsr_in_valid_o;
    logic [7:0]     lfsr_rnd;
    logic [N-1:0]   gnt_o;
    logic [7:0]     rnd_o;
    logic           rnd_valid_o;
    logic           ready_o;
    logic [15:0]    stat_grant_cnt_o;
    logic [15:0]    stat_reject_cnt_o;

    logic       use_stub = 1'b0;
    logic [7:0] stub_val = 8'd0;
    logic [7:0] lfsr_q;

    int n_checks = 0;
    int n_errors = 0;
    bit started  = 0;

    always #5 clk = ~clk;

    lfsr_rng_arbiter #(.NUM_REQ(N), .WARMUP(W), .SAFE_SEED(8'hA5)) dut (
        .clk               (clk),
        .rst               (rst),
        .seed_i            (seed_in),
        .seed_start_i      (seed_start),
        .req_i             (req),
        .mode_i            (mode),
        .lfsr_seed_o       (lfsr_seed_o),
        .lfsr_in_valid_o   (lfsr_in_valid_o),
        .lfsr_rnd_i        (lfsr_rnd),
        .gnt_o             (gnt_o),
        .rnd_o             (rnd_o),
        .rnd_valid_o       (rnd_valid_o),
        .ready_o           (ready_o),
        .stat_grant_cnt_o  (stat_grant_cnt_o),
        .stat_reject_cnt_o (stat_reject_cnt_o)
    );

    // Galois LFSR standing in for the real instance: 01 -> 9C -> 4E -> 27 -> 8F
    function automatic logic [7:0] lfsr_step(input logic [7:0] r);
        return r[0] ? ((r >> 1) ^ 8'h9C) : (r >> 1);
    endfunction

    always @(posedge clk) begin
        if (rst) lfsr_q <= 8'd0;
        else if (lfsr_in_valid_o) lfsr_q <= lfsr_seed_o;
        else lfsr_q <= lfsr_step(lfsr_q);
    end

    assign lfsr_rnd = use_stub ? stub_val : lfsr_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Behavioural model: cycles since seeding decide readiness; plain modulo arithmetic
    bit         m_seeded;
    int         m_csd;
    int         m_ptr;
    bit         m_rdy;
    bit         m_found;
    int         m_sel;
    int         m_r;
    int         m_md;
    logic [N-1:0] m_gnt;
    logic [7:0] m_rnd;
    logic [7:0] m_seed;
    int         m_gcnt;
    int         m_rcnt;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_seeded = 0; m_csd = 0; m_ptr = 0; m_gnt = '0; m_rnd = 8'd0;
                m_seed = 8'd0; m_gcnt = 0; m_rcnt = 0;
            end else begin
                m_rdy = m_seeded && (m_csd >= 1 + int'(W));
                m_gnt = '0;
                if (seed_start) begin
                    m_seeded = 1; m_csd = 0; m_gcnt = 0; m_rcnt = 0;
                    m_seed = (seed_in == 8'd0) ? 8'hA5 : seed_in;
                end else begin
                    if (m_seeded && m_csd < 1000) m_csd++;
                    if (m_rdy) begin
                        m_found = 0;
                        m_sel = 0;
                        for (int i = 0; i < int'(N); i++) begin
                            if (!m_found && req[(m_ptr + i) % N]) begin
                                m_found = 1;
                                m_sel = (m_ptr + i) % N;
                            end
                        end
                        if (m_found) begin
                            m_r  = int'(lfsr_rnd);
                            m_md = int'(mode[2*m_sel +: 2]);
                            if (m_md == 2 && (m_r == 0 || m_r > 240)) begin
                                if (m_rcnt < 65535) m_rcnt++;
                            end else begin
                                m_gnt[m_sel] = 1'b1;
                                if (m_md == 1) m_rnd = 8'(m_r % 4);
                                else if (m_md == 2) m_rnd = 8'(((m_r - 1) % 40) + 1);
                                else m_rnd = 8'(m_r);
                                m_ptr = (m_sel + 1) % N;
                                if (m_gcnt < 65535) m_gcnt++;
                            end
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("gnt", 32'(gnt_o), 32'(m_gnt));
            chk("rnd", 32'(rnd_o), 32'(m_rnd));
            chk("rnd_valid", 32'(rnd_valid_o), 32'(|m_gnt));
            chk("ready", 32'(ready_o), 32'(m_seeded && (m_csd >= 1 + int'(W))));
            chk("in_valid", 32'(lfsr_in_valid_o), 32'(m_seeded && m_csd == 0));
            chk("lfsr_seed", 32'(lfsr_seed_o), 32'(m_seed));
`ifdef RNG_STATS_EN
            chk("grant_cnt", 32'(stat_grant_cnt_o), 32'(m_gcnt));
            chk("reject_cnt", 32'(stat_reject_cnt_o), 32'(m_rcnt));
`else
            chk("grant_cnt", 32'(stat_grant_cnt_o), 32'd0);
            chk("reject_cnt", 32'(stat_reject_cnt_o), 32'd0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int  cnt;
    bit  need_seed;
    logic [N-1:0] rot_exp [5];

    initial begin
        rot_exp = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        tick();
        started = 1;
        tick();
        rst = 1'b0;
        chk("reset_gnt", 32'(gnt_o), 32'd0);
        chk("reset_ready", 32'(ready_o), 32'd0);
        chk("reset_seed", 32'(lfsr_seed_o), 32'd0);

        // Seed 01 and measure warm-up latency
        seed_in = 8'h01; seed_start = 1'b1;
        tick();
        seed_start = 1'b0;
        chk("seed_valid", 32'(lfsr_in_valid_o), 32'd1);
        chk("seed_val", 32'(lfsr_seed_o), 32'h01);
        tick();
        chk("seed_valid_once", 32'(lfsr_in_valid_o), 32'd0);
        cnt = 1;
        while (!ready_o && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("ready_latency", 32'(cnt), 32'(1 + W));

        // Mode 2 on 9C, mode 1 on 4E
        use_stub = 1'b1; stub_val = 8'h9C; req = 4'b0001; mode = 8'b00_00_00_10;
        tick();
        chk("m2_gnt", 32'(gnt_o), 32'b0001);
        chk("m2_rnd", 32'(rnd_o), 32'd36);
        req[0] = 1'b0; stub_val = 8'h4E; req[1] = 1'b1; mode[3:2] = 2'd1;
        tick();
        chk("m1_gnt", 32'(gnt_o), 32'b0010);
        chk("m1_rnd", 32'(rnd_o), 32'd2);
        req[1] = 1'b0;

        // Rejection of F5 then accept 29
        stub_val = 8'hF5; req[2] = 1'b1; mode[5:4] = 2'd2;
        tick();
        chk("rej_gnt", 32'(gnt_o), 32'd0);
`ifdef RNG_STATS_EN
        chk("rej_cnt", 32'(stat_reject_cnt_o), 32'd1);
`endif
        stub_val = 8'h29;
        tick();
        chk("retry_gnt", 32'(gnt_o), 32'b0100);
        chk("retry_rnd", 32'(rnd_o), 32'd1);
        req[2] = 1'b0;

        // Round-robin rotation with all requesting, pointer at 3
        use_stub = 1'b0; mode = '0; req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rotate", 32'(gnt_o), 32'(rot_exp[i]));
        end
        req = '0;

        // Reseed with zero seed during RUN while req[3] pends
        seed_in = 8'h00; seed_start = 1'b1; req = 4'b1000;
        tick();
        seed_start = 1'b0;
        chk("reseed_gnt", 32'(gnt_o), 32'd0);
        chk("safe_seed", 32'(lfsr_seed_o), 32'hA5);
        chk("reseed_ready", 32'(ready_o), 32'd0);
        for (int i = 0; i < int'(W); i++) begin
            tick();
            chk("warm_ready", 32'(ready_o), 32'd0);
            chk("warm_gnt", 32'(gnt_o), 32'd0);
        end
        tick();
        chk("rerun_ready", 32'(ready_o), 32'd1);
        tick();
        chk("pending_gnt", 32'(gnt_o), 32'b1000);
        req = '0;

        // Reset mid-grant
        req = 4'b1111;
        tick();
        chk("pre_rst_valid", 32'(rnd_valid_o), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_valid", 32'(rnd_valid_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_gcnt", 32'(stat_grant_cnt_o), 32'd0);
        chk("rst_rcnt", 32'(stat_reject_cnt_o), 32'd0);
        tick();
        tick();
        chk("idle_ready", 32'(ready_o), 32'd0);
        chk("idle_gnt", 32'(gnt_o), 32'd0);
        req = '0;

        // Randomized traffic
        seed_in = 8'h5A; seed_start = 1'b1;
        tick();
        seed_start = 1'b0;
        need_seed = 0;
        for (int c = 0; c < 3000; c++) begin
            seed_start = need_seed || ($urandom_range(0, 299) == 0);
            need_seed  = 0;
            seed_in    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            rst        = ($urandom_range(0, 799) == 0);
            if (rst) need_seed = 1;
            use_stub   = ($urandom_range(0, 2) == 0);
            stub_val   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(230, 255))
                                                     : 8'($urandom);
            for (int k = 0; k < int'(N); k++) begin
                if (gnt_o[k]) begin
                    req[k] = 1'b0;
                end else if (!req[k] && $urandom_range(0, 2) == 0) begin
                    req[k] = 1'b1;
                    mode[2*k +: 2] = 2'($urandom);
                end
            end
            tick();
        end
        rst = 1'b0; seed_start = 1'b0; req = '0;
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
